// File: rtl/up_down_counter_mux7seg.sv
// up_down_counter_mux7seg
//
// Multi-digit up/down counter with a built-in multiplexed 7-segment driver.
// The count advances once every STEP_DIV enabled clocks. It counts either in
// hex or digit-wise BCD and can be parallel-loaded. A free-running refresh
// counter scans the digits onto a shared, active-low segment bus.
//
// Ports
//   clk      system clock, all state on the rising edge
//   reset    asynchronous reset, active low
//   en       count enable; low freezes both the count and the step prescaler
//   upDown   1 = count up, 0 = count down (sampled only on a step tick)
//   load     synchronous load strobe; has priority over stepping; ignores en
//   loadVal  load value, digit i in bits [4i+3:4i]
//   count    registered count
//   carry    one-cycle pulse after a wrap (up) or a borrow (down)
//   seg      active-low segments {dp, g..a}; dp is always off
//   anode    active-low digit select, one-hot-low
module up_down_counter_mux7seg #(
    parameter int DIGITS      = 4,
    parameter int BCD         = 0,
    parameter int STEP_DIV    = 50_000_000,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  upDown,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   loadVal,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     anode
);

    localparam int CW     = 4 * DIGITS;
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [REF_W-1:0]  REF_ONE   = REF_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);

    logic [STEP_W-1:0] step_cnt;
    logic [REF_W-1:0]  ref_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic              step_tick;

    logic [CW-1:0]     hex_next;
    logic              hex_wrap;
    logic [CW-1:0]     bcd_next;
    logic              bcd_ripple;
    logic [CW-1:0]     step_next;
    logic              step_wrap;
    logic [CW-1:0]     load_digits;

    logic [3:0]        cur_digit;
    logic [DIGITS-1:0] anode_next;

    // Active-low hex font, dp bit (bit 7) kept high.
    function automatic logic [7:0] font(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign step_tick = en && (step_cnt == STEP_LAST);

    // Plain binary step; the wrap flag marks all-ones going up or zero going down.
    always_comb begin
        hex_next = upDown ? (count + CNT_ONE) : (count - CNT_ONE);
        hex_wrap = upDown ? (&count) : ~(|count);
    end

    // BCD step: the ripple flag travels up through the digits while each digit
    // rolls over (9->0 going up, 0->9 going down). If it survives past the top
    // digit, the whole count wrapped.
    always_comb begin
        bcd_next   = count;
        bcd_ripple = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_ripple) begin
                if (upDown) begin
                    if (count[4*i +: 4] >= 4'd9) begin
                        bcd_next[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_next[4*i +: 4] = count[4*i +: 4] + 4'd1;
                        bcd_ripple         = 1'b0;
                    end
                end else begin
                    if (count[4*i +: 4] == 4'd0) begin
                        bcd_next[4*i +: 4] = 4'd9;
                    end else begin
                        bcd_next[4*i +: 4] = count[4*i +: 4] - 4'd1;
                        bcd_ripple         = 1'b0;
                    end
                end
            end
        end
    end

    // In BCD mode out-of-range load digits saturate to 9, so the count never
    // holds an illegal decimal digit.
    always_comb begin
        load_digits = loadVal;
        if (BCD != 0) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (loadVal[4*i +: 4] > 4'd9) begin
                    load_digits[4*i +: 4] = 4'd9;
                end
            end
        end
    end

    always_comb begin
        if (BCD != 0) begin
            step_next = bcd_next;
            step_wrap = bcd_ripple;
        end else begin
            step_next = hex_next;
            step_wrap = hex_wrap;
        end
    end

    // Count path: load > step tick > hold. carry defaults low every cycle, so
    // it can only be high for the single cycle after a wrapping tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
            count    <= '0;
            carry    <= 1'b0;
        end else if (load) begin
            step_cnt <= '0;
            count    <= load_digits;
            carry    <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (en) begin
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + STEP_ONE;
            end
            if (step_tick) begin
                count <= step_next;
                carry <= step_wrap;
            end
        end
    end

    // Scan timing runs freely, unaffected by en and load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt  <= '0;
            scan_idx <= '0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt  <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_ONE;
        end else begin
            ref_cnt <= ref_cnt + REF_ONE;
        end
    end

    // Digit select as an explicit mux, so the index never reaches past the
    // count when DIGITS is not a power of two.
    always_comb begin
        cur_digit  = 4'd0;
        anode_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_digit     = count[4*i +: 4];
                anode_next[i] = 1'b0;
            end
        end
    end

    // seg and anode are registered together, so they change on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg   <= 8'hFF;
            anode <= '1;
        end else begin
            seg   <= font(cur_digit);
            anode <= anode_next;
        end
    end

endmodule

// File: doc/up_down_counter_mux7seg.md
Name:
up_down_counter_mux7seg

Overview:
- Parametrised multi-digit up/down counter with a built-in time-multiplexed 7-segment display driver.
- Replaces the single-digit, count-every-clock counter with:
  - a prescaled count rate
  - an enable
  - a synchronous parallel load
  - hex or BCD counting
  - a wrap/borrow pulse
  - an N-digit anode scan
- Sits between the board switches/buttons and the 7-segment display; the count is also exported for other blocks.

Parameters:
DIGITS, 4, number of displayed 4-bit digits; legal 1..4
BCD, 0, 0 = hex (count range 0..16^DIGITS-1), 1 = decimal (each digit 0..9, range 0..10^DIGITS-1)
STEP_DIV, 50_000_000, clk cycles per count step; legal >= 1
REFRESH_DIV, 100_000, clk cycles each digit is driven during the scan; legal >= 1

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  count enable; 0 freezes count and step prescaler
upDown  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe
loadVal  input  4*DIGITS  value for load; digit i = bits [4i+3:4i]
count  output  4*DIGITS  current count, registered
carry  output  1  one-cycle pulse on wrap (up) or borrow (down)
seg  output  8  active-low segments, bit7 = dp (always 1 = off), bits6..0 = g..a
anode  output  DIGITS  active-low digit select, one-hot-low

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, carry=0, step prescaler=0, scan index=0, refresh counter=0
  - seg=8'hFF, anode=all 1s
  - Outputs stay blank while reset is held.
  - After reset deasserts, seg/anode become valid at the first clk edge.
- Step prescaler:
  - Counts 0..STEP_DIV-1 while en=1 and wraps to 0.
  - Step tick = en && prescaler==STEP_DIV-1.
  - STEP_DIV=1 gives a tick every enabled cycle.
  - en=0 holds the prescaler value.
- Priority per clk edge: load > step tick > hold.
- Load:
  - count <= loadVal; prescaler <= 0; carry <= 0.
  - Load is independent of en.
  - In BCD mode any loaded digit >9 is stored as 9.
- Step tick, hex mode:
  - count <= count +/- 1 modulo 16^DIGITS.
  - Up from all-F gives 0 with carry=1.
  - Down from 0 gives all-F with carry=1.
- Step tick, BCD mode:
  - Digit-wise ripple.
  - Up: digit 9 becomes 0 and increments the next digit.
  - Down: digit 0 becomes 9 and decrements the next digit.
  - Up from all-9 gives 0 with carry=1.
  - Down from 0 gives all-9 with carry=1.
- carry:
  - Registered; high exactly the one cycle after the wrapping edge.
  - 0 on all other cycles.
- upDown is sampled only on the tick edge; changes between ticks have no effect.
- Display scan:
  - The refresh counter runs 0..REFRESH_DIV-1 continuously; it is independent of en and load.
  - At REFRESH_DIV-1 the scan index advances i -> i+1, and DIGITS-1 -> 0.
  - DIGITS=1: index stays at 0 and anode is constantly 0.
  - seg and anode are registered together from the same scan index and the current count.
  - Latency: 1 cycle after an index or count change.
  - anode[i]=0 only for the active index.
  - seg encodes digit i with the standard hex font, active-low (examples below).
  - 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
  - The font covers all 16 codes; a BCD digit is never >9 by construction.
- Reset asserted mid-step or mid-scan forces the reset values immediately, with no clk edge required.
- All counters are width-sized for their DIV parameter.
- No combinational path from any input to any output.

Test Plan:
Common setup for all scenarios: DIGITS=2, STEP_DIV=4, REFRESH_DIV=2 unless stated.
- Reset then hex count-up: reset low 3 cycles, then high, en=1, upDown=1, BCD=0.
  - count goes 00 -> 01 -> 02, changing every 4 cycles.
  - seg/anode are FF/11 during reset.
  - anode then alternates 10, 01 every 2 cycles.
  - seg is C0 on digit0 until count=01, then F9.
- Hex wrap and borrow: load FE, count up.
  - Count goes FF -> 00; carry is 1 for exactly one cycle at 00.
  - Then upDown=0: 00 -> FF, carry pulses again.
- BCD ripple, BCD=1:
  - load 19, count up: 20.
  - load 99, count up: 00 with carry.
  - load 00, count down: 99 with carry.
  - load AF: count=99.
- Load priority: load=1 on the same edge as a step tick with loadVal=37.
  - count=37, no increment, carry=0, prescaler restarts.
  - Next step occurs 4 enabled cycles later.
- Enable freeze: en=0 for 10 cycles mid-prescale.
  - count and prescaler hold; the anode scan keeps toggling.
  - en=1: the step occurs after the remaining prescaler cycles only.
- Async reset mid-operation: drop reset between clk edges at count=42.
  - count=00, seg=FF, anode=11 immediately, before the next clk edge.
